// File: rtl/frame_head_sync.sv
// Receive-side frame-header synchroniser: hunts for the sync code, flywheels on
// frame boundaries, checks counter/reserved header fields and forwards payload.
module frame_head_sync #(
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_MAX    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic [3:0]  sync_code_length,
  input  logic [79:0] sync_code_content,
  input  logic [3:0]  cntr_length,
  input  logic [47:0] cntr_init,
  input  logic [7:0]  cntr_step,
  input  logic        res_flag,
  input  logic [7:0]  res_content,
  input  logic [7:0]  framehead_len,
  input  logic [15:0] frame_len,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        frame_start,
  output logic        hdr_valid,
  output logic [47:0] cntr_value,
  output logic        cntr_err,
  output logic        res_err,
  output logic        locked,
  output logic        sync_lost,
  output logic        cfg_err,
  output logic [15:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, HDR, PAYLOAD, VERIFY} state_t;

  typedef struct packed {
    logic [3:0]  sync_len;
    logic [79:0] sync_code;
    logic [3:0]  cntr_len;
    logic [47:0] cntr_init;
    logic [7:0]  cntr_step;
    logic        res_flag;
    logic [7:0]  res_content;
    logic [7:0]  fh_len;
    logic [15:0] frame_len;
  } cfg_t;

  function automatic logic cfg_illegal(cfg_t c);
    logic [8:0] need;
    need = {5'd0, c.sync_len} + {5'd0, c.cntr_len} + {8'd0, c.res_flag};
    return (c.sync_len == 4'd0) || (c.sync_len > 4'd10) ||
           (c.cntr_len == 4'd0) || (c.cntr_len > 4'd6) ||
           ({1'b0, c.fh_len} < need) || (c.frame_len <= {8'd0, c.fh_len});
  endfunction

  function automatic logic [79:0] code_mask(logic [3:0] len);
    return (80'd1 << {len, 3'b000}) - 80'd1;
  endfunction

  function automatic logic [47:0] cntr_mask(logic [3:0] len);
    return (48'd1 << {len, 3'b000}) - 48'd1;
  endfunction

  // Byte k of the sync code in arrival order (k = 0 is the most significant byte).
  function automatic logic [7:0] code_byte(logic [79:0] code, logic [3:0] len, logic [3:0] k);
    logic [3:0]  pos;
    logic [79:0] sh;
    pos = len - 4'd1 - k;
    sh  = code >> {pos, 3'b000};
    return sh[7:0];
  endfunction

  function automatic logic [15:0] sat_add(logic [15:0] a, logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t      state_q, state_d;
  cfg_t        cfg_in, cfg_q, cfg_d;
  logic [79:0] win_q, win_d;
  logic [15:0] idx_q, idx_d;
  logic [47:0] cntr_sh_q, cntr_sh_d;
  logic [7:0]  res_byte_q, res_byte_d;
  logic        vmiss_q, vmiss_d;
  logic        fly_q, fly_d;
  logic        ref_valid_q, ref_valid_d;
  logic [7:0]  hit_q, hit_d;
  logic [7:0]  miss_q, miss_d;
  logic [7:0]  dout_q, dout_d;
  logic        dout_valid_q, dout_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [47:0] cntr_value_q, cntr_value_d;
  logic        cntr_err_q, cntr_err_d;
  logic        res_err_q, res_err_d;
  logic        locked_q, locked_d;
  logic        sync_lost_q, sync_lost_d;
  logic        cfg_err_q, cfg_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        cfg_bad, miss_evt, in_cntr, verdict_miss;
  logic [79:0] shifted, cmask;
  logic [47:0] cntr_new, cntr_exp;
  logic [7:0]  res_new, hit_n, miss_n;
  logic [15:0] sync_len16, cend16, fh_last16, pay_last16;
  logic [1:0]  err_inc;

  always_comb begin
    cfg_in = {sync_code_length, sync_code_content, cntr_length, cntr_init, cntr_step,
              res_flag, res_content, framehead_len, frame_len};
    cfg_d  = (state_q == HUNT) ? cfg_in : cfg_q;
    cfg_bad = cfg_illegal(cfg_q);

    sync_len16 = {12'd0, cfg_q.sync_len};
    cend16     = sync_len16 + {12'd0, cfg_q.cntr_len};
    fh_last16  = {8'd0, cfg_q.fh_len} - 16'd1;
    pay_last16 = cfg_q.frame_len - {8'd0, cfg_q.fh_len} - 16'd1;
    shifted    = {win_q[71:0], din};
    cmask      = code_mask(cfg_q.sync_len);
    in_cntr    = (idx_q >= sync_len16) && (idx_q < cend16);
    cntr_new   = in_cntr ? {cntr_sh_q[39:0], din} : cntr_sh_q;
    res_new    = (cfg_q.res_flag && (idx_q == cend16)) ? din : res_byte_q;
    cntr_exp   = (cntr_value_q + {40'd0, cfg_q.cntr_step}) & cntr_mask(cfg_q.cntr_len);
    hit_n      = (hit_q >= 8'(LOCK_FRAMES)) ? hit_q : hit_q + 8'd1;
    miss_n     = miss_q + 8'd1;
    verdict_miss = vmiss_q |
                   (din != code_byte(cfg_q.sync_code, cfg_q.sync_len, idx_q[3:0]));

    state_d       = state_q;
    win_d         = win_q;
    idx_d         = idx_q;
    cntr_sh_d     = cntr_sh_q;
    res_byte_d    = res_byte_q;
    vmiss_d       = vmiss_q;
    fly_d         = fly_q;
    ref_valid_d   = ref_valid_q;
    hit_d         = hit_q;
    miss_d        = miss_q;
    dout_d        = din_valid ? din : dout_q;
    dout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    hdr_valid_d   = 1'b0;
    cntr_value_d  = cntr_value_q;
    cntr_err_d    = 1'b0;
    res_err_d     = 1'b0;
    locked_d      = locked_q;
    sync_lost_d   = 1'b0;
    cfg_err_d     = (state_q == HUNT) ? cfg_illegal(cfg_in) : cfg_err_q;
    miss_evt      = 1'b0;

    case (state_q)
      HUNT: begin
        ref_valid_d  = 1'b0;
        cntr_value_d = cfg_q.cntr_init;
        if (din_valid) begin
          win_d = shifted;
          if (!cfg_bad && ((shifted & cmask) == (cfg_q.sync_code & cmask))) begin
            state_d       = HDR;
            idx_d         = sync_len16;
            cntr_sh_d     = '0;
            fly_d         = 1'b0;
            hit_d         = 8'd1;
            miss_d        = 8'd0;
            frame_start_d = 1'b1;
            locked_d      = (LOCK_FRAMES <= 1);
          end
        end
      end
      HDR: begin
        if (din_valid) begin
          cntr_sh_d  = cntr_new;
          res_byte_d = res_new;
          idx_d      = idx_q + 16'd1;
          if (idx_q == fh_last16) begin
            idx_d   = 16'd0;
            state_d = PAYLOAD;
            // Flywheeled headers are not trusted: no report, no checks.
            if (!fly_q) begin
              hdr_valid_d  = 1'b1;
              cntr_value_d = cntr_new;
              ref_valid_d  = 1'b1;
              cntr_err_d   = ref_valid_q && (cntr_new != cntr_exp);
              res_err_d    = cfg_q.res_flag && (res_new != cfg_q.res_content);
            end
          end
        end
      end
      PAYLOAD: begin
        if (din_valid) begin
          dout_valid_d = 1'b1;
          idx_d        = idx_q + 16'd1;
          if (idx_q == pay_last16) begin
            idx_d   = 16'd0;
            vmiss_d = 1'b0;
            state_d = VERIFY;
          end
        end
      end
      VERIFY: begin
        if (din_valid) begin
          vmiss_d = verdict_miss;
          idx_d   = idx_q + 16'd1;
          if (idx_q == sync_len16 - 16'd1) begin
            idx_d     = sync_len16;
            cntr_sh_d = '0;
            if (!verdict_miss) begin
              state_d       = HDR;
              fly_d         = 1'b0;
              frame_start_d = 1'b1;
              miss_d        = 8'd0;
              hit_d         = hit_n;
              if (hit_n >= 8'(LOCK_FRAMES)) locked_d = 1'b1;
            end else begin
              miss_evt = 1'b1;
              miss_d   = miss_n;
              if (miss_n >= 8'(MISS_MAX)) begin
                state_d     = HUNT;
                locked_d    = 1'b0;
                sync_lost_d = 1'b1;
                hit_d       = 8'd0;
                win_d       = '0;
                idx_d       = 16'd0;
              end else begin
                state_d       = HDR;
                fly_d         = 1'b1;
                ref_valid_d   = 1'b0;
                frame_start_d = 1'b1;
              end
            end
          end
        end
      end
      default: state_d = HUNT;
    endcase

    err_inc   = {1'b0, cntr_err_d} + {1'b0, res_err_d} + {1'b0, miss_evt};
    err_cnt_d = sat_add(err_cnt_q, err_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      win_q         <= '0;
      idx_q         <= '0;
      vmiss_q       <= 1'b0;
      fly_q         <= 1'b0;
      ref_valid_q   <= 1'b0;
      hit_q         <= '0;
      miss_q        <= '0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hdr_valid_q   <= 1'b0;
      cntr_value_q  <= '0;
      cntr_err_q    <= 1'b0;
      res_err_q     <= 1'b0;
      locked_q      <= 1'b0;
      sync_lost_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      idx_q         <= idx_d;
      vmiss_q       <= vmiss_d;
      fly_q         <= fly_d;
      ref_valid_q   <= ref_valid_d;
      hit_q         <= hit_d;
      miss_q        <= miss_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
      hdr_valid_q   <= hdr_valid_d;
      cntr_value_q  <= cntr_value_d;
      cntr_err_q    <= cntr_err_d;
      res_err_q     <= res_err_d;
      locked_q      <= locked_d;
      sync_lost_q   <= sync_lost_d;
      cfg_err_q     <= cfg_err_d;
      err_cnt_q     <= err_cnt_d;
    end
    cfg_q      <= reset ? cfg_in : cfg_d;
    cntr_sh_q  <= cntr_sh_d;
    res_byte_q <= res_byte_d;
  end

  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;
  assign hdr_valid   = hdr_valid_q;
  assign cntr_value  = cntr_value_q;
  assign cntr_err    = cntr_err_q;
  assign res_err     = res_err_q;
  assign locked      = locked_q;
  assign sync_lost   = sync_lost_q;
  assign cfg_err     = cfg_err_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_frame_head_sync.sv
// Scoreboard bench for frame_head_sync: directed frames push expected events,
// a negedge monitor pops and compares whenever the DUT presents an output.
module tb_frame_head_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic        din_valid;
  logic [3:0]  sync_code_length;
  logic [79:0] sync_code_content;
  logic [3:0]  cntr_length;
  logic [47:0] cntr_init;
  logic [7:0]  cntr_step;
  logic        res_flag;
  logic [7:0]  res_content;
  logic [7:0]  framehead_len;
  logic [15:0] frame_len;
  logic [7:0]  dout;
  logic        dout_valid, frame_start, hdr_valid, cntr_err, res_err;
  logic        locked, sync_lost, cfg_err;
  logic [47:0] cntr_value;
  logic [15:0] err_cnt;

  frame_head_sync dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .sync_code_length(sync_code_length), .sync_code_content(sync_code_content),
    .cntr_length(cntr_length), .cntr_init(cntr_init), .cntr_step(cntr_step),
    .res_flag(res_flag), .res_content(res_content), .framehead_len(framehead_len),
    .frame_len(frame_len), .dout(dout), .dout_valid(dout_valid),
    .frame_start(frame_start), .hdr_valid(hdr_valid), .cntr_value(cntr_value),
    .cntr_err(cntr_err), .res_err(res_err), .locked(locked), .sync_lost(sync_lost),
    .cfg_err(cfg_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [47:0] cv;
    logic        ce;
    logic        re;
  } hdr_t;

  logic [7:0]  pay_q[$];
  logic        fs_q[$];
  hdr_t        hdr_q[$];
  logic [15:0] lost_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected pulse, expected none", name);
  endtask

  always @(negedge clk) begin : monitor
    logic lk;
    hdr_t h;
    logic [7:0] b;
    logic [15:0] e;
    if (frame_start) begin
      if (fs_q.size() == 0) unexpected("frame_start");
      else begin lk = fs_q.pop_front(); chk("locked_at_frame_start", locked, lk); end
    end
    if (hdr_valid) begin
      if (hdr_q.size() == 0) unexpected("hdr_valid");
      else begin
        h = hdr_q.pop_front();
        chk("cntr_value", cntr_value, h.cv);
        chk("cntr_err", cntr_err, h.ce);
        chk("res_err", res_err, h.re);
      end
    end else if (cntr_err || res_err) unexpected("err_without_hdr_valid");
    if (dout_valid) begin
      if (pay_q.size() == 0) unexpected("dout_valid");
      else begin b = pay_q.pop_front(); chk("dout", dout, b); end
    end
    if (sync_lost) begin
      if (lost_q.size() == 0) unexpected("sync_lost");
      else begin
        e = lost_q.pop_front();
        chk("err_cnt_at_sync_lost", err_cnt, e);
        chk("locked_at_sync_lost", locked, 1'b0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
    din = b;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  // One frame: sync (EB90 or corrupt EB91), 2-byte counter, reserved, one pad byte,
  // then npay payload bytes n*8+i. Expectations are the hand-derived flags passed in.
  task automatic run_frame(input logic sync_ok, input logic [15:0] cntr, input logic [7:0] res,
                           input int n, input int npay,
                           input logic e_fs, input logic e_lock, input logic e_hdr,
                           input logic e_ce, input logic e_re, input logic e_pay,
                           input logic e_lost, input logic [15:0] e_err);
    hdr_t h;
    if (e_fs) fs_q.push_back(e_lock);
    if (e_hdr) begin
      h.cv = {32'd0, cntr};
      h.ce = e_ce;
      h.re = e_re;
      hdr_q.push_back(h);
    end
    if (e_pay) for (int i = 0; i < npay; i++) pay_q.push_back(8'(n * 8 + i));
    if (e_lost) lost_q.push_back(e_err);
    send_byte(8'hEB);
    send_byte(sync_ok ? 8'h90 : 8'h91);
    send_byte(cntr[15:8]);
    send_byte(cntr[7:0]);
    send_byte(res);
    send_byte(8'h00);
    for (int i = 0; i < npay; i++) send_byte(8'(n * 8 + i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    sync_code_length  = 4'd2;
    sync_code_content = 80'hEB90;
    cntr_length   = 4'd2;
    cntr_init     = 48'hABC;
    cntr_step     = 8'd1;
    res_flag      = 1'b1;
    res_content   = 8'h5A;
    framehead_len = 8'd6;
    frame_len     = 16'd16;
    idle(3);
    chk("reset_dout_valid", dout_valid, 1'b0);
    chk("reset_locked", locked, 1'b0);
    chk("reset_err_cnt", err_cnt, 16'd0);
    chk("reset_cfg_err", cfg_err, 1'b0);
    chk("reset_cntr_value", cntr_value, 48'd0);
    reset = 1'b0;
    idle(2);

    // Lock and counting
    run_frame(1, 16'h0010, 8'h5A, 1, 10, 1, 0, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0011, 8'h5A, 2, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0012, 8'h5A, 3, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0013, 8'h5A, 4, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    idle(3);
    chk("err_cnt_lock_phase", err_cnt, 16'd0);
    chk("locked_lock_phase", locked, 1'b1);

    // Counter wrap and jump
    do_reset();
    run_frame(1, 16'hFFFE, 8'h5A, 5, 10, 1, 0, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'hFFFF, 8'h5A, 6, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0000, 8'h5A, 7, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0005, 8'h5A, 8, 10, 1, 1, 1, 1, 0, 1, 0, 0);
    idle(3);
    chk("err_cnt_wrap_phase", err_cnt, 16'd1);

    // Reset during payload
    run_frame(1, 16'h0006, 8'h5A, 9, 5, 1, 1, 1, 0, 0, 1, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_dout", dout, 8'h00);
    chk("midreset_dout_valid", dout_valid, 1'b0);
    chk("midreset_locked", locked, 1'b0);
    chk("midreset_err_cnt", err_cnt, 16'd0);
    chk("midreset_cntr_value", cntr_value, 48'd0);
    chk("midreset_pulses", {frame_start, hdr_valid, cntr_err, res_err, sync_lost}, 5'd0);
    reset = 1'b0;
    idle(2);

    // Flywheel then loss, then relock
    run_frame(1, 16'h0020, 8'h5A, 10, 10, 1, 0, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0021, 8'h5A, 11, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    run_frame(0, 16'h0022, 8'h5A, 12, 10, 1, 1, 0, 0, 0, 1, 0, 0);
    run_frame(0, 16'h0023, 8'h5A, 13, 10, 1, 1, 0, 0, 0, 1, 0, 0);
    run_frame(0, 16'h0024, 8'h5A, 14, 10, 0, 0, 0, 0, 0, 0, 1, 16'd3);
    run_frame(1, 16'h0025, 8'h5A, 15, 10, 1, 0, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0026, 8'h5A, 16, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    idle(3);
    chk("err_cnt_flywheel_phase", err_cnt, 16'd3);

    // Reserved mismatch
    run_frame(1, 16'h0027, 8'h5B, 17, 10, 1, 1, 1, 0, 1, 1, 0, 0);
    run_frame(1, 16'h0028, 8'h5A, 18, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    idle(3);
    chk("err_cnt_res_phase", err_cnt, 16'd4);

    // Illegal configuration, then restore
    framehead_len = 8'd4;
    do_reset();
    idle(3);
    chk("cfg_err_illegal", cfg_err, 1'b1);
    chk("cntr_value_unlocked_init", cntr_value, 48'hABC);
    run_frame(1, 16'h0030, 8'h5A, 19, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    framehead_len = 8'd6;
    idle(3);
    chk("cfg_err_restored", cfg_err, 1'b0);
    run_frame(1, 16'h0031, 8'h5A, 20, 10, 1, 0, 1, 0, 0, 1, 0, 0);
    run_frame(1, 16'h0032, 8'h5A, 21, 10, 1, 1, 1, 0, 0, 1, 0, 0);
    idle(5);
    chk("err_cnt_cfg_phase", err_cnt, 16'd0);

    chk("pay_q_drained", pay_q.size(), 0);
    chk("fs_q_drained", fs_q.size(), 0);
    chk("hdr_q_drained", hdr_q.size(), 0);
    chk("lost_q_drained", lost_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
